// File: rtl/output_serializer.sv
// Pairs left/right ALU samples and shifts them out MSB-first with a frame-valid strobe.
// Optional sticky overrun flag port `ovf` when SER_OVF_FLAG_EN is defined.
module output_serializer #(
  parameter int unsigned W = 40
) (
  input  logic         sClk,
  input  logic         reset,
  input  logic         start,
  input  logic         yL_Ready,
  input  logic [W-1:0] yL,
  input  logic         yR_Ready,
  input  logic [W-1:0] yR,
  output logic         OutReady,
  output logic         OutputL,
`ifdef SER_OVF_FLAG_EN
  output logic         OutputR,
  output logic         ovf
`else
  output logic         OutputR
`endif
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t        state, state_n;
  logic [W-1:0]  capL, capR, pendL, pendR, shL, shR;
  logic [W-1:0]  srcL_c, srcR_c;
  logic          fullL, fullR, pend_full;
  logic [CW-1:0] cnt;
  logic          pair_c, finish_c, load_c, load_pend_c;
  logic          cap_to_sh_c, cap_to_pend_c, cap_take_c;

  // Serial bits come straight off the shifter MSBs; the shifter is cleared when idle.
  assign OutputL = shL[W-1];
  assign OutputR = shR[W-1];

  // Pair routing and next-state decode.
  always_comb begin
    state_n       = state;
    pair_c        = fullL & fullR;
    finish_c      = (state == S_SHIFT) && (cnt == CNT_LAST);
    load_c        = ((state == S_IDLE) || finish_c) && (pend_full || pair_c);
    load_pend_c   = load_c && pend_full;
    cap_to_sh_c   = load_c && !pend_full;
    cap_to_pend_c = pair_c && !cap_to_sh_c && (!pend_full || load_pend_c);
    cap_take_c    = cap_to_sh_c || cap_to_pend_c;
    srcL_c        = pend_full ? pendL : capL;
    srcR_c        = pend_full ? pendR : capR;
    case (state)
      S_IDLE:  if (load_c) state_n = S_SHIFT;
      S_SHIFT: if (finish_c && !load_c) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge sClk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      OutReady <= 1'b0;
    end else if (start) begin
      state    <= S_IDLE;
      OutReady <= 1'b0;
    end else begin
      state    <= state_n;
      OutReady <= (state_n == S_SHIFT);
    end
  end

  always_ff @(posedge sClk or negedge reset) begin
    if (!reset) begin
      capL      <= '0;
      capR      <= '0;
      fullL     <= 1'b0;
      fullR     <= 1'b0;
      pendL     <= '0;
      pendR     <= '0;
      pend_full <= 1'b0;
      shL       <= '0;
      shR       <= '0;
      cnt       <= '0;
    end else if (start) begin
      capL      <= '0;
      capR      <= '0;
      fullL     <= 1'b0;
      fullR     <= 1'b0;
      pendL     <= '0;
      pendR     <= '0;
      pend_full <= 1'b0;
      shL       <= '0;
      shR       <= '0;
      cnt       <= '0;
    end else begin
      // A strobe always wins the capture slot, even as its old pair moves out.
      if (yL_Ready) begin
        capL  <= yL;
        fullL <= 1'b1;
      end else if (cap_take_c) begin
        fullL <= 1'b0;
      end
      if (yR_Ready) begin
        capR  <= yR;
        fullR <= 1'b1;
      end else if (cap_take_c) begin
        fullR <= 1'b0;
      end

      if (cap_to_pend_c) begin
        pendL     <= capL;
        pendR     <= capR;
        pend_full <= 1'b1;
      end else if (load_pend_c) begin
        pend_full <= 1'b0;
      end

      if (load_c) begin
        shL <= srcL_c;
        shR <= srcR_c;
        cnt <= '0;
      end else if (finish_c) begin
        shL <= '0;
        shR <= '0;
        cnt <= '0;
      end else if (state == S_SHIFT) begin
        shL <= shL << 1;
        shR <= shR << 1;
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef SER_OVF_FLAG_EN
  logic ovr_c;
  assign ovr_c = ((yL_Ready && fullL) || (yR_Ready && fullR)) && !cap_take_c;

  always_ff @(posedge sClk or negedge reset) begin
    if (!reset)      ovf <= 1'b0;
    else if (start)  ovf <= 1'b0;
    else if (ovr_c)  ovf <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_output_serializer.sv
// Directed self-checking bench for output_serializer (W=40).
module tb_output_serializer;

  localparam int unsigned W = 40;

  logic         sClk;
  logic         reset;
  logic         start;
  logic         yL_Ready;
  logic [W-1:0] yL;
  logic         yR_Ready;
  logic [W-1:0] yR;
  logic         OutReady;
  logic         OutputL;
  logic         OutputR;
`ifdef SER_OVF_FLAG_EN
  logic         ovf;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  output_serializer #(.W(W)) dut (
    .sClk     (sClk),
    .reset    (reset),
    .start    (start),
    .yL_Ready (yL_Ready),
    .yL       (yL),
    .yR_Ready (yR_Ready),
    .yR       (yR),
    .OutReady (OutReady),
    .OutputL  (OutputL),
`ifdef SER_OVF_FLAG_EN
    .OutputR  (OutputR),
    .ovf      (ovf)
`else
    .OutputR  (OutputR)
`endif
  );

  initial sClk = 1'b0;
  always #5 sClk = ~sClk;

  task automatic step();
    @(posedge sClk);
    #1;
  endtask

  task automatic pair(input logic [W-1:0] l, input logic [W-1:0] r);
    yL = l;
    yR = r;
    yL_Ready = 1'b1;
    yR_Ready = 1'b1;
    step();
    yL_Ready = 1'b0;
    yR_Ready = 1'b0;
  endtask

  // Gathers serial bits while OutReady is high; bounded so a stuck frame still ends.
  task automatic collect_frame(output logic [W-1:0] l, output logic [W-1:0] r, output int len);
    l = '0;
    r = '0;
    len = 0;
    while (OutReady === 1'b1 && len < 200) begin
      l = {l[W-2:0], OutputL};
      r = {r[W-2:0], OutputR};
      len++;
      step();
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] l, r;
    int len;
    reset = 1'b0;
    repeat (2) @(posedge sClk);
    #1;
    chk_cnt++;
    if ({OutReady, OutputL, OutputR} !== 3'b000)
      $display("FAIL reset_init: got %b expected 000", {OutReady, OutputL, OutputR});
    else pass_cnt++;
    reset = 1'b1;
    step();
    pair(40'h8000000001, 40'h0000000000);
    step();
    chk_cnt++;
    if ({OutReady, OutputL, OutputR} !== 3'b110)
      $display("FAIL reset_frame_start: got %b expected 110", {OutReady, OutputL, OutputR});
    else pass_cnt++;
    repeat (9) step();
    #2 reset = 1'b0;
    #1;
    chk_cnt++;
    if ({OutReady, OutputL, OutputR} !== 3'b000)
      $display("FAIL reset_async: got %b expected 000", {OutReady, OutputL, OutputR});
    else pass_cnt++;
    #2 reset = 1'b1;
    step();
    step();
    chk_cnt++;
    if (OutReady !== 1'b0)
      $display("FAIL reset_stays_idle: got %b expected 0", OutReady);
    else pass_cnt++;
    pair(40'h5A5A5A5A5A, 40'h3C3C3C3C3C);
    step();
    collect_frame(l, r, len);
    chk_cnt++;
    if (len !== 40 || l !== 40'h5A5A5A5A5A || r !== 40'h3C3C3C3C3C)
      $display("FAIL reset_fresh_frame: got len=%0d L=%h R=%h expected len=40 L=5a5a5a5a5a R=3c3c3c3c3c",
               len, l, r);
    else pass_cnt++;
  endtask

  task automatic test_single();
    logic [W-1:0] l, r;
    int len;
    step();
    pair(40'hF00000000F, 40'h0123456789);
    chk_cnt++;
    if (OutReady !== 1'b0)
      $display("FAIL single_latency: got OutReady=%b expected 0", OutReady);
    else pass_cnt++;
    step();
    collect_frame(l, r, len);
    chk_cnt++;
    if (len !== 40)
      $display("FAIL single_len: got %0d expected 40", len);
    else pass_cnt++;
    chk_cnt++;
    if (l !== 40'hF00000000F)
      $display("FAIL single_L: got %h expected f00000000f", l);
    else pass_cnt++;
    chk_cnt++;
    if (r !== 40'h0123456789)
      $display("FAIL single_R: got %h expected 0123456789", r);
    else pass_cnt++;
  endtask

  task automatic test_staggered();
    logic [W-1:0] l, r;
    int len;
    bit early = 1'b0;
    step();
    yL = 40'h123456789A;
    yL_Ready = 1'b1;
    step();
    yL_Ready = 1'b0;
    for (int i = 1; i < 7; i++) begin
      step();
      if (OutReady !== 1'b0) early = 1'b1;
    end
    yR = 40'hFEDCBA9876;
    yR_Ready = 1'b1;
    step();
    yR_Ready = 1'b0;
    chk_cnt++;
    if (early || OutReady !== 1'b0)
      $display("FAIL stagger_early: got early=%b OutReady=%b expected 0 0", early, OutReady);
    else pass_cnt++;
    step();
    collect_frame(l, r, len);
    chk_cnt++;
    if (len !== 40 || l !== 40'h123456789A || r !== 40'hFEDCBA9876)
      $display("FAIL stagger_frame: got len=%0d L=%h R=%h expected len=40 L=123456789a R=fedcba9876",
               len, l, r);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] l1, r1, l2, r2;
    logic last_l, last_r, end_rdy;
    bit gap = 1'b0;
    l1 = '0; r1 = '0; l2 = '0; r2 = '0;
    last_l = 1'b0; last_r = 1'b0; end_rdy = 1'b1;
    step();
    pair(40'hC35A00FF12, 40'h0F0FF0F001);
    step();
    for (int i = 0; i < 81; i++) begin
      if (i < 80) begin
        if (OutReady !== 1'b1) gap = 1'b1;
        if (i < 40) begin
          l1 = {l1[W-2:0], OutputL};
          r1 = {r1[W-2:0], OutputR};
        end else begin
          l2 = {l2[W-2:0], OutputL};
          r2 = {r2[W-2:0], OutputR};
        end
      end
      if (i == 79) begin
        last_l = OutputL;
        last_r = OutputR;
      end
      if (i == 80) end_rdy = OutReady;
      if (i == 19) begin
        yL = 40'h0000000001;
        yR = 40'h0000000002;
        yL_Ready = 1'b1;
        yR_Ready = 1'b1;
      end else begin
        yL_Ready = 1'b0;
        yR_Ready = 1'b0;
      end
      if (i < 80) step();
    end
    chk_cnt++;
    if (gap || end_rdy !== 1'b0)
      $display("FAIL b2b_contiguous: got gap=%b end_rdy=%b expected 0 0", gap, end_rdy);
    else pass_cnt++;
    chk_cnt++;
    if (l1 !== 40'hC35A00FF12 || r1 !== 40'h0F0FF0F001)
      $display("FAIL b2b_frame1: got L=%h R=%h expected L=c35a00ff12 R=0f0ff0f001", l1, r1);
    else pass_cnt++;
    chk_cnt++;
    if (l2 !== 40'h0000000001 || r2 !== 40'h0000000002)
      $display("FAIL b2b_frame2: got L=%h R=%h expected L=0000000001 R=0000000002", l2, r2);
    else pass_cnt++;
    chk_cnt++;
    if ({last_l, last_r} !== 2'b10)
      $display("FAIL b2b_last_bit: got %b expected 10", {last_l, last_r});
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [W-1:0] f1l, f1r, f2l, f2r, f3l, f3r;
    logic end_rdy;
    bit gap = 1'b0;
    f1l = '0; f1r = '0; f2l = '0; f2r = '0; f3l = '0; f3r = '0;
    end_rdy = 1'b1;
    step();
    for (int i = 0; i <= 121; i++) begin
      yL_Ready = (i == 0 || i == 3 || i == 6 || i == 9);
      yR_Ready = (i == 0 || i == 3 || i == 6);
      if (i == 0) begin
        yL = 40'h1111111111; yR = 40'h2222222222;
      end else if (i == 3) begin
        yL = 40'h3333333333; yR = 40'h4444444444;
      end else if (i == 6) begin
        yL = 40'h5555555555; yR = 40'h6666666666;
      end else if (i == 9) begin
        yL = 40'h77777777FF;
      end
      step();
      if (i >= 1 && i <= 120) begin
        if (OutReady !== 1'b1) gap = 1'b1;
        if (i <= 40) begin
          f1l = {f1l[W-2:0], OutputL}; f1r = {f1r[W-2:0], OutputR};
        end else if (i <= 80) begin
          f2l = {f2l[W-2:0], OutputL}; f2r = {f2r[W-2:0], OutputR};
        end else begin
          f3l = {f3l[W-2:0], OutputL}; f3r = {f3r[W-2:0], OutputR};
        end
      end
      if (i == 121) end_rdy = OutReady;
    end
    yL_Ready = 1'b0;
    yR_Ready = 1'b0;
    chk_cnt++;
    if (gap || end_rdy !== 1'b0)
      $display("FAIL ovr_contiguous: got gap=%b end_rdy=%b expected 0 0", gap, end_rdy);
    else pass_cnt++;
    chk_cnt++;
    if (f1l !== 40'h1111111111 || f1r !== 40'h2222222222)
      $display("FAIL ovr_frame1: got L=%h R=%h expected L=1111111111 R=2222222222", f1l, f1r);
    else pass_cnt++;
    chk_cnt++;
    if (f2l !== 40'h3333333333 || f2r !== 40'h4444444444)
      $display("FAIL ovr_pending: got L=%h R=%h expected L=3333333333 R=4444444444", f2l, f2r);
    else pass_cnt++;
    chk_cnt++;
    if (f3l !== 40'h77777777FF || f3r !== 40'h6666666666)
      $display("FAIL ovr_overwrite: got L=%h R=%h expected L=77777777ff R=6666666666", f3l, f3r);
    else pass_cnt++;
`ifdef SER_OVF_FLAG_EN
    chk_cnt++;
    if (ovf !== 1'b1)
      $display("FAIL ovr_flag: got %b expected 1", ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_start();
    logic [W-1:0] l, r;
    int len;
    bit rose = 1'b0;
    step();
    pair(40'hAAAAAAAAAA, 40'h5555555555);
    repeat (2) step();
    pair(40'h0F0F0F0F0F, 40'hF0F0F0F0F0);
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk_cnt++;
    if ({OutReady, OutputL, OutputR} !== 3'b000)
      $display("FAIL start_clear: got %b expected 000", {OutReady, OutputL, OutputR});
    else pass_cnt++;
`ifdef SER_OVF_FLAG_EN
    chk_cnt++;
    if (ovf !== 1'b0)
      $display("FAIL start_ovf: got %b expected 0", ovf);
    else pass_cnt++;
`endif
    for (int i = 0; i < 60; i++) begin
      step();
      if (OutReady !== 1'b0) rose = 1'b1;
    end
    chk_cnt++;
    if (rose)
      $display("FAIL start_pending_dropped: got OutReady rise expected none");
    else pass_cnt++;
    start = 1'b1;
    yL = 40'hFFFFFFFFFF;
    yR = 40'hFFFFFFFFFF;
    yL_Ready = 1'b1;
    yR_Ready = 1'b1;
    step();
    start = 1'b0;
    yL_Ready = 1'b0;
    yR_Ready = 1'b0;
    step();
    step();
    chk_cnt++;
    if (OutReady !== 1'b0)
      $display("FAIL start_priority: got OutReady=%b expected 0", OutReady);
    else pass_cnt++;
    pair(40'h9876543210, 40'h0000FFFF00);
    step();
    collect_frame(l, r, len);
    chk_cnt++;
    if (len !== 40 || l !== 40'h9876543210 || r !== 40'h0000FFFF00)
      $display("FAIL start_fresh_frame: got len=%0d L=%h R=%h expected len=40 L=9876543210 R=0000ffff00",
               len, l, r);
    else pass_cnt++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    yL_Ready = 1'b0;
    yR_Ready = 1'b0;
    yL       = '0;
    yR       = '0;
    test_reset();
    test_single();
    test_staggered();
    test_back_to_back();
    test_overrun();
    test_start();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
